ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send side of the keyboard link, complementing the existing PS/2 receive controller.
- Sends one command byte to the keyboard (e.g. 0xFF reset, 0xED set-LEDs, 0xF4 enable) using the standard request-to-send protocol:
  - host inhibits clock,
  - host drives start bit,
  - device clocks out the frame,
  - device acknowledges.
- Drives the open-drain PS2_CLK/PS2_DAT lines through active-high pull-low enables.
- Reports completion, acknowledge and timeout status to the game/keyboard logic.

Parameters:
- INHIBIT_CYCLES, 5000: CLOCK_50 cycles ps2_clk held low before the start bit (100 us).
- SETUP_CYCLES, 50: cycles clock and data are both held low before the clock is released (1 us).
- START_TIMEOUT, 750000: maximum cycles from clock release to the first device falling edge (15 ms).
- XFER_TIMEOUT, 100000: maximum cycles from the first falling edge to line-idle after the acknowledge (2 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- tx_valid  in  1  command byte available.
- tx_data  in  8  command byte.
- tx_ready  out  1  block idle, can accept a byte.
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pin level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release.
- busy  out  1  transaction in progress; the receiver must ignore line activity while high.
- done  out  1  single-cycle pulse at the end of every accepted transaction.
- ack_ok  out  1  device acknowledged the last transaction; held until the next accept.
- timeout  out  1  last transaction aborted on timeout; held until the next accept.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE.
  - ps2_clk_oe = 0 and ps2_dat_oe = 0: both lines released at once.
  - tx_ready = 1; busy, done, ack_ok and timeout all 0.
  - Bit counter, timers and synchronizers cleared; synchronizers reset to 1.
- Line sampling:
  - ps2_clk_in and ps2_dat_in each pass through a 2-FF synchronizer (reset value 1).
  - fall_edge = previous synced clk & ~current synced clk.
  - Edge latency is 3 CLOCK_50 cycles after the pin edge.
- Accept: in IDLE, tx_valid & tx_ready latches tx_data and parity = ~^tx_data (odd parity). On the accept:
  - ack_ok and timeout are cleared, busy = 1, tx_ready = 0.
  - The next state is INHIBIT.
- tx_valid is ignored while busy; no queueing.
- States:
  - IDLE: both oe = 0.
  - INHIBIT: clk_oe = 1, dat_oe = 0 for exactly INHIBIT_CYCLES cycles, then go to SETUP.
  - SETUP: clk_oe = 1, dat_oe = 1 (start bit) for SETUP_CYCLES cycles, then go to WAIT_CLK.
  - WAIT_CLK:
    - clk_oe = 0, dat_oe = 1.
    - On fall_edge, drive bit0 (dat_oe = ~bit0), set bit counter = 1, start the transfer timer and go to XFER.
    - If START_TIMEOUT cycles elapse with no edge, go to ABORT.
  - XFER: on each fall_edge:
    - Counter 1..7: drive bit[counter], data LSB first.
    - Counter 8: drive parity.
    - Counter 9: release data (stop bit, dat_oe = 0).
    - Counter 10: sample the synced dat level; ack_ok = (dat == 0); go to WAIT_IDLE.
    - The counter increments on every edge.
  - WAIT_IDLE: both oe = 0; when synced clk = 1 and synced dat = 1, go to DONE.
  - DONE: done = 1 for one cycle, busy = 0, then go to IDLE.
  - ABORT:
    - Both oe = 0, timeout = 1, ack_ok = 0.
    - done = 1 for one cycle, busy = 0, then go to IDLE. WAIT_IDLE is skipped.
- Transfer timer: runs continuously in XFER and WAIT_IDLE. Reaching XFER_TIMEOUT goes to ABORT, even if the acknowledge was already sampled (ack_ok forced to 0).
- Data bits change only on device falling edges, so data is stable at the device's rising-edge sample.
- Timers saturate at their limit; there is no wrap.
- tx_ready = (state == IDLE); busy = ~tx_ready.
- A NACK (dat high at edge 10) still completes through WAIT_IDLE and DONE with ack_ok = 0 and timeout = 0.

Test Plan:
- Send 0xED; device BFM clocks at ~12 kHz and acks. Required:
  - clk_oe low for 5000 cycles.
  - Device reads frame start 0, data 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1.
  - done pulses once; ack_ok = 1, timeout = 0; tx_ready returns 1.
- Send 0x01 and 0xFF back-to-back, with the second tx_valid held during the first transfer. Required:
  - Second byte accepted only after the first done pulse.
  - Parity bits 0 and 1 respectively.
- Device holds dat high at edge 10 (NACK) -> done pulses, ack_ok = 0, timeout = 0.
- Device never clocks -> ABORT exactly START_TIMEOUT cycles after WAIT_CLK entry. Required: both oe = 0, timeout = 1, done pulses once.
- Device stops clocking after edge 4 -> ABORT XFER_TIMEOUT cycles after edge 1. Required: lines released, timeout = 1.
- reset_n asserted mid-XFER (after edge 5). Required:
  - ps2_clk_oe and ps2_dat_oe fall to 0 in the same time step, asynchronously.
  - After release, tx_ready = 1 and ack_ok = timeout = 0.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, device-clocked frame, ack check.
// Latency: device falling edges are acted on 3 CLOCK_50 cycles after the pin edge.
// Backpressure: tx_ready only in IDLE; tx_valid is ignored while a transaction is busy.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 50,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout
);

    localparam int T01  = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int T23  = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int TMAX = (T01 > T23) ? T01 : T23;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SETUP,
        S_WAIT_CLK,
        S_XFER,
        S_WAIT_IDLE,
        S_DONE,
        S_ABORT
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [3:0]      bit_cnt;
    logic [7:0]      data_q;
    logic            parity_q;
    logic            clk_s1, clk_s2, clk_prev;
    logic            dat_s1, dat_s2;
    logic            fall_edge;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat_in;
            dat_s2   <= dat_s1;
        end
    end

    assign fall_edge = clk_prev & ~clk_s2;
    assign tx_ready  = (state == S_IDLE);
    assign busy      = ~tx_ready;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            data_q     <= '0;
            parity_q   <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            done       <= 1'b0;
            ack_ok     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        data_q     <= tx_data;
                        parity_q   <= ~^tx_data;
                        ack_ok     <= 1'b0;
                        timeout    <= 1'b0;
                        timer      <= '0;
                        ps2_clk_oe <= 1'b1;
                        ps2_dat_oe <= 1'b0;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (timer == INH_LAST) begin
                        timer      <= '0;
                        ps2_dat_oe <= 1'b1;
                        state      <= S_SETUP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_SETUP: begin
                    if (timer == SETUP_LAST) begin
                        timer      <= '0;
                        ps2_clk_oe <= 1'b0;
                        state      <= S_WAIT_CLK;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WAIT_CLK: begin
                    if (fall_edge) begin
                        ps2_dat_oe <= ~data_q[0];
                        bit_cnt    <= 4'd1;
                        timer      <= '0;
                        state      <= S_XFER;
                    end else if (timer == START_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        timeout    <= 1'b1;
                        ack_ok     <= 1'b0;
                        state      <= S_ABORT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_XFER: begin
                    // Transfer timeout wins over a coincident device edge.
                    if (timer == XFER_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        timeout    <= 1'b1;
                        ack_ok     <= 1'b0;
                        state      <= S_ABORT;
                    end else begin
                        timer <= timer + TW'(1);
                        if (fall_edge) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt <= 4'd7) begin
                                ps2_dat_oe <= ~data_q[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                ps2_dat_oe <= ~parity_q;
                            end else if (bit_cnt == 4'd9) begin
                                ps2_dat_oe <= 1'b0;
                            end else begin
                                ack_ok <= ~dat_s2;
                                state  <= S_WAIT_IDLE;
                            end
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (timer == XFER_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        timeout    <= 1'b1;
                        ack_ok     <= 1'b0;
                        state      <= S_ABORT;
                    end else begin
                        timer <= timer + TW'(1);
                        if (clk_s2 && dat_s2) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                S_ABORT: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a device bus-functional model and frame scoreboard.
module tb_ps2_host_tx;

    localparam int INH   = 300;
    localparam int SETUP = 20;
    localparam int STO   = 2000;
    localparam int XTO   = 3000;
    localparam int HALF  = 40;
    localparam int LIMIT = 8000;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       busy, done, ack_ok, timeout;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int inh_cnt  = 0;
    int setup_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cnt  = 0;
    int acc_cyc  = 0;

    logic [10:0] exp_q[$];

    assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
    assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SETUP),
        .START_TIMEOUT (STO),
        .XFER_TIMEOUT  (XTO)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .done      (done),
        .ack_ok    (ack_ok),
        .timeout   (timeout)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (ps2_clk_oe && !ps2_dat_oe) inh_cnt <= inh_cnt + 1;
        if (ps2_clk_oe && ps2_dat_oe)  setup_cnt <= setup_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (tx_valid && tx_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #3;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b);
        step();
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        do begin
            @(negedge CLOCK_50);
            g++;
        end while (!done && g < LIMIT);
        chk(tag, done, 1'b1);
    endtask

    // Device model: waits for the start bit, then clocks n_edges falling edges.
    task automatic dev_frame(input int n_edges, input bit ack, output logic [10:0] frm, output int e1);
        int g = 0;
        frm = '0;
        e1  = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && g < LIMIT) begin
            @(negedge CLOCK_50);
            g++;
        end
        chk("bfm_start_bit_seen", 32'(g < LIMIT), 32'd1);
        repeat (10) step();
        frm[0] = ps2_dat_in;
        for (int k = 1; k <= n_edges; k++) begin
            dev_clk = 1'b0;
            if (k == 1) e1 = cyc;
            repeat (HALF) step();
            dev_clk = 1'b1;
            frm[k] = ps2_dat_in;
            repeat (HALF) step();
        end
        if (n_edges == 10) begin
            dev_dat = ack ? 1'b0 : 1'b1;
            repeat (HALF / 2) step();
            dev_clk = 1'b0;
            repeat (HALF) step();
            dev_clk = 1'b1;
            dev_dat = 1'b1;
        end
    endtask

    initial begin
        logic [10:0] frm;
        logic [10:0] expf;
        int e1, base_done, base_inh, base_setup, base_acc, c0, c1, g;

        #5 reset_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack_ok", ack_ok, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        step();
        reset_n = 1'b1;

        // 0xED with acknowledge
        base_done = done_cnt; base_inh = inh_cnt; base_setup = setup_cnt;
        exp_q.push_back(mk_frame(8'hED));
        send(8'hED);
        @(negedge CLOCK_50);
        chk("ed_busy", busy, 1'b1);
        dev_frame(10, 1'b1, frm, e1);
        expf = exp_q.pop_front();
        chk("ed_frame", frm, expf);
        wait_done("ed_done");
        repeat (3) step();
        chk("ed_inhibit_cycles", inh_cnt - base_inh, INH);
        chk("ed_setup_cycles", setup_cnt - base_setup, SETUP);
        chk("ed_done_count", done_cnt - base_done, 1);
        chk("ed_ack_ok", ack_ok, 1'b1);
        chk("ed_timeout", timeout, 1'b0);
        chk("ed_tx_ready", tx_ready, 1'b1);

        // 0x01 then 0xFF with tx_valid held through the first transfer
        base_done = done_cnt; base_acc = acc_cnt;
        exp_q.push_back(mk_frame(8'h01));
        exp_q.push_back(mk_frame(8'hFF));
        step();
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        step();
        tx_data  = 8'hFF;
        dev_frame(10, 1'b1, frm, e1);
        expf = exp_q.pop_front();
        chk("b2b_frame_01", frm, expf);
        wait_done("b2b_done_1");
        step();
        tx_valid = 1'b0;
        repeat (2) step();
        chk("b2b_accept_count", acc_cnt - base_acc, 2);
        chk("b2b_accept_after_done", 32'(acc_cyc >= done_cyc), 32'd1);
        chk("b2b_busy_second", busy, 1'b1);
        dev_frame(10, 1'b1, frm, e1);
        expf = exp_q.pop_front();
        chk("b2b_frame_ff", frm, expf);
        wait_done("b2b_done_2");
        repeat (2) step();
        chk("b2b_done_count", done_cnt - base_done, 2);
        chk("b2b_ack_ok", ack_ok, 1'b1);

        // NACK from the device
        base_done = done_cnt;
        exp_q.push_back(mk_frame(8'hF4));
        send(8'hF4);
        dev_frame(10, 1'b0, frm, e1);
        expf = exp_q.pop_front();
        chk("nack_frame", frm, expf);
        wait_done("nack_done");
        repeat (2) step();
        chk("nack_ack_ok", ack_ok, 1'b0);
        chk("nack_timeout", timeout, 1'b0);
        chk("nack_done_count", done_cnt - base_done, 1);

        // Device never clocks
        base_done = done_cnt;
        send(8'hFF);
        g = 0;
        do begin @(negedge CLOCK_50); g++; end
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && g < LIMIT);
        c0 = cyc;
        g = 0;
        do begin @(negedge CLOCK_50); g++; end
        while (ps2_dat_oe != 1'b0 && g < LIMIT);
        c1 = cyc;
        chk("sto_abort_cycles", c1 - c0, STO);
        chk("sto_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        chk("sto_timeout", timeout, 1'b1);
        wait_done("sto_done");
        repeat (2) step();
        chk("sto_done_count", done_cnt - base_done, 1);
        chk("sto_ack_ok", ack_ok, 1'b0);

        // Device stops after edge 4
        base_done = done_cnt;
        send(8'h00);
        dev_frame(4, 1'b1, frm, e1);
        g = 0;
        do begin @(negedge CLOCK_50); g++; end
        while (timeout != 1'b1 && g < LIMIT);
        chk("xto_abort_cycles", cyc - e1, 3 + XTO);
        chk("xto_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        wait_done("xto_done");
        repeat (2) step();
        chk("xto_timeout", timeout, 1'b1);
        chk("xto_done_count", done_cnt - base_done, 1);

        // Asynchronous reset mid-transfer after edge 5
        send(8'h00);
        dev_frame(5, 1'b1, frm, e1);
        chk("arst_pre_dat_oe", ps2_dat_oe, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("arst_oe_immediate", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        chk("arst_ready_immediate", tx_ready, 1'b1);
        step();
        reset_n = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        chk("arst_tx_ready", tx_ready, 1'b1);
        chk("arst_flags", {busy, ack_ok, timeout}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
